// File: rtl/mx_int8_dequant_bf16.sv
// MXINT8 block decoder: latches one E8M0 scale + BLOCK_SIZE int8 elements, streams bf16 LANES per beat.
// First beat one cycle after accept; out_ready_i low freezes all outputs and keeps in_ready_o low.
module mx_int8_dequant_bf16 #(
  parameter int BLOCK_SIZE = 32,
  parameter int LANES      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [7:0]              scale_i,
  input  logic [8*BLOCK_SIZE-1:0] elem_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [16*LANES-1:0]     out_data_o,
  output logic                    out_last_o,
  output logic [LANES-1:0]        out_uflow_o,
  output logic [LANES-1:0]        out_oflow_o
);

  localparam int NBEATS = BLOCK_SIZE / LANES;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [7:0]              r_scale, w_scale_nxt;
  logic [8*BLOCK_SIZE-1:0] r_elem, w_elem_nxt;
  logic                    r_out_valid, r_out_last;
  logic [16*LANES-1:0]     r_out_data, w_data_nxt;
  logic [LANES-1:0]        r_out_uflow, r_out_oflow, w_uflow_nxt, w_oflow_nxt;
  logic [17:0]             w_lane_nxt [LANES];
  logic                    w_out_fire, w_accept;

  // Result packing: {uflow, oflow, bf16}
  function automatic logic [17:0] f_cvt(input logic [7:0] s, input logic [7:0] e);
    logic [7:0]        m;
    logic [6:0]        mant;
    logic [2:0]        p;
    logic signed [9:0] ex;
    logic              sg;
    sg = e[7];
    m  = sg ? (8'd0 - e) : e;
    p  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = 3'(i);
    end
    mant = 7'(m << (3'd7 - p));
    ex   = $signed({2'b00, s}) + $signed({7'b0, p}) - 10'sd6;
    if (s == 8'hFF)          f_cvt = {2'b00, 16'h7FC0};
    else if (e == 8'd0)      f_cvt = 18'd0;
    else if (ex <= 10'sd0)   f_cvt = {2'b10, sg, 15'b0};
    else if (ex >= 10'sd255) f_cvt = {2'b01, sg, 8'hFF, 7'b0};
    else                     f_cvt = {2'b00, sg, ex[7:0], mant};
  endfunction

  assign w_out_fire = r_out_valid & out_ready_i;
  assign in_ready_o = (r_state == ST_IDLE) | (w_out_fire & r_out_last);
  assign w_accept   = in_valid_i & in_ready_o;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_scale_nxt = r_scale;
    w_elem_nxt  = r_elem;
    if (w_accept) begin
      w_state_nxt = ST_STREAM;
      w_cnt_nxt   = '0;
      w_scale_nxt = scale_i;
      w_elem_nxt  = elem_i;
    end else if (r_state == ST_STREAM && w_out_fire) begin
      if (r_out_last) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  // Outputs are computed from next-cycle block/counter so they register in step with the state.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [7:0] w_e;
    assign w_e           = w_elem_nxt[8*(int'(w_cnt_nxt)*LANES + j) +: 8];
    assign w_lane_nxt[j] = f_cvt(w_scale_nxt, w_e);
  end

  always_comb begin
    w_data_nxt  = '0;
    w_uflow_nxt = '0;
    w_oflow_nxt = '0;
    for (int j = 0; j < LANES; j++) begin
      w_data_nxt[16*j +: 16] = w_lane_nxt[j][15:0];
      w_uflow_nxt[j]         = w_lane_nxt[j][17];
      w_oflow_nxt[j]         = w_lane_nxt[j][16];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_scale     <= '0;
      r_elem      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_uflow <= '0;
      r_out_oflow <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_scale     <= w_scale_nxt;
      r_elem      <= w_elem_nxt;
      r_out_valid <= (w_state_nxt == ST_STREAM);
      r_out_last  <= (w_state_nxt == ST_STREAM) && (w_cnt_nxt == LAST_BEAT);
      r_out_data  <= w_data_nxt;
      r_out_uflow <= w_uflow_nxt;
      r_out_oflow <= w_oflow_nxt;
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_last_o  = r_out_last;
  assign out_data_o  = r_out_data;
  assign out_uflow_o = r_out_uflow;
  assign out_oflow_o = r_out_oflow;

endmodule

// File: tb/tb_mx_int8_dequant_bf16.sv
// Bench for mx_int8_dequant_bf16: directed corner blocks plus random blocks under random backpressure,
// scored against an arithmetic bf16 reference model.
module tb_mx_int8_dequant_bf16;
  localparam int BS = 32;
  localparam int LN = 4;
  localparam int NB = BS / LN;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [7:0]      scale_i;
  logic [8*BS-1:0] elem_i;
  logic            out_valid_o;
  wire             out_ready_i;
  logic [16*LN-1:0] out_data_o;
  logic            out_last_o;
  logic [LN-1:0]   out_uflow_o;
  logic [LN-1:0]   out_oflow_o;

  logic rdy_rand, rdy_ctl, rdy_bit;
  assign out_ready_i = rdy_rand ? rdy_bit : rdy_ctl;

  mx_int8_dequant_bf16 #(.BLOCK_SIZE(BS), .LANES(LN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .scale_i(scale_i), .elem_i(elem_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o),
    .out_uflow_o(out_uflow_o), .out_oflow_o(out_oflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  u;
    logic [3:0]  o;
    logic        l;
  } beat_t;
  beat_t exp_q[$];

  // Value = e * 2^(S-133), written as sign * 1.frac * 2^(E-127).
  function automatic logic [17:0] ref_lane(int s, int e);
    int sgn, mag, k, ex, frac, data;
    if (s == 255) return {2'b00, 16'h7FC0};
    if (e == 0) return 18'd0;
    sgn = (e < 0) ? 1 : 0;
    mag = (e < 0) ? -e : e;
    k   = $clog2(mag + 1) - 1;
    ex  = s + k - 6;
    if (ex <= 0) return {2'b10, 16'(sgn * 32768)};
    if (ex >= 255) return {2'b01, 16'(sgn * 32768 + 255 * 128)};
    frac = (mag * 128) / (1 << k) - 128;
    data = sgn * 32768 + ex * 128 + frac;
    return {2'b00, 16'(data)};
  endfunction

  function automatic void push_block(input logic [7:0] s, input logic [8*BS-1:0] e);
    beat_t bt;
    logic [17:0] r;
    logic signed [7:0] ev;
    for (int b = 0; b < NB; b++) begin
      bt = '0;
      for (int j = 0; j < LN; j++) begin
        ev = e[8*(b*LN+j) +: 8];
        r  = ref_lane(int'(s), int'(ev));
        bt.d[16*j +: 16] = r[15:0];
        bt.u[j] = r[17];
        bt.o[j] = r[16];
      end
      bt.l = (b == NB - 1);
      exp_q.push_back(bt);
    end
  endfunction

  function automatic logic [8*BS-1:0] rand_elems();
    logic [8*BS-1:0] v;
    for (int k = 0; k < BS/4; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  always @(negedge clk_i) begin
    beat_t bt;
    if (rst_ni === 1'b1) begin
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) check_eq("unexpected_beat", 64'(out_valid_o), 64'd0);
        else begin
          bt = exp_q.pop_front();
          check_eq("beat_data", out_data_o, bt.d);
          check_eq("beat_uflow", 64'(out_uflow_o), 64'(bt.u));
          check_eq("beat_oflow", 64'(out_oflow_o), 64'(bt.o));
          check_eq("beat_last", 64'(out_last_o), 64'(bt.l));
        end
      end
      if (in_valid_i && in_ready_o) push_block(scale_i, elem_i);
    end
  end

  initial begin
    rdy_bit = 1'b1;
    forever begin
      @(posedge clk_i);
      #1 rdy_bit = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_block(input logic [7:0] s, input logic [8*BS-1:0] e);
    int t = 0;
    in_valid_i = 1'b1;
    scale_i    = s;
    elem_i     = e;
    @(negedge clk_i);
    while (!in_ready_o && t < 400) begin
      @(negedge clk_i);
      t++;
    end
    check_eq("accept_ready", 64'(in_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    scale_i    = 8'($urandom);
    elem_i     = rand_elems();
    check_eq("lat1_valid", 64'(out_valid_o), 64'd1);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk_i);
    while (out_valid_o && t < 400) begin
      @(negedge clk_i);
      t++;
    end
    check_eq("drain_idle", 64'(out_valid_o), 64'd0);
    check_eq("drain_queue", 64'(exp_q.size()), 64'd0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [8*BS-1:0] e;
    logic [63:0]     saved;
    int b, cyc, hold, nlast, nv, t;
    logic acc2, done;

    rst_ni = 1'b0; in_valid_i = 1'b0; scale_i = '0; elem_i = '0;
    rdy_rand = 1'b0; rdy_ctl = 1'b1;
    #12;
    check_eq("rst_in_ready", 64'(in_ready_o), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid_o), 64'd0);
    check_eq("rst_out_last", 64'(out_last_o), 64'd0);
    check_eq("rst_out_data", out_data_o, 64'd0);
    check_eq("rst_flags", 64'({out_uflow_o, out_oflow_o}), 64'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    e = rand_elems(); e[31:0] = 32'h0301_8040;
    send_block(8'h7F, e);
    check_eq("t1_beat0_data", out_data_o, 64'h3D40_3C80_C000_3F80);
    wait_idle();

    send_block(8'hFF, rand_elems());
    check_eq("t2_nan_data", out_data_o, {4{16'h7FC0}});
    wait_idle();

    e = rand_elems(); e[31:0] = 32'h7F00_FF01;
    send_block(8'h01, e);
    check_eq("t3_data", out_data_o, 64'h00FE_0000_8000_0000);
    check_eq("t3_uflow", 64'(out_uflow_o), 64'h3);
    wait_idle();

    e = rand_elems(); e[31:0] = 32'h0040_7F80;
    send_block(8'hFE, e);
    check_eq("t4_data", out_data_o, 64'h0000_7F00_7F7E_FF80);
    check_eq("t4_oflow", 64'(out_oflow_o), 64'h1);
    wait_idle();

    // Stall three cycles on beat 2.
    send_block(8'($urandom_range(100, 150)), rand_elems());
    b = 0; cyc = 0; hold = 0; nlast = 0; saved = '0;
    while (b < NB && cyc < 60) begin
      rdy_ctl = !(b == 2 && hold < 3);
      @(negedge clk_i);
      if (!rdy_ctl) begin
        if (hold == 0) saved = out_data_o;
        else check_eq("stall_hold", out_data_o, saved);
        check_eq("stall_in_ready", 64'(in_ready_o), 64'd0);
        hold++;
      end else if (b == 2 && hold == 3) check_eq("stall_release", out_data_o, saved);
      if (out_valid_o && out_ready_i) begin
        b++;
        if (out_last_o) nlast++;
      end
      cyc++;
      @(posedge clk_i); #1;
    end
    rdy_ctl = 1'b1;
    check_eq("stall_cycles", 64'(cyc), 64'd11);
    check_eq("stall_last_once", 64'(nlast), 64'd1);
    wait_idle();

    // Back-to-back blocks with in_valid_i held high.
    in_valid_i = 1'b1; scale_i = 8'h80; elem_i = rand_elems();
    @(negedge clk_i);
    check_eq("b2b_idle_ready", 64'(in_ready_o), 64'd1);
    @(posedge clk_i); #1;
    scale_i = 8'h70; elem_i = rand_elems();
    nv = 0; acc2 = 1'b0; done = 1'b0; t = 0;
    while (!done && t < 60) begin
      @(negedge clk_i);
      if (out_valid_o) nv++; else done = 1'b1;
      if (in_valid_i && in_ready_o) begin
        check_eq("b2b_accept_on_last", 64'(out_last_o & out_valid_o & out_ready_i), 64'd1);
        acc2 = 1'b1;
      end
      @(posedge clk_i); #1;
      if (acc2) in_valid_i = 1'b0;
      t++;
    end
    check_eq("b2b_accepted", 64'(acc2), 64'd1);
    check_eq("b2b_valid_beats", 64'(nv), 64'd16);
    check_eq("b2b_queue", 64'(exp_q.size()), 64'd0);

    // Reset pulse while beat 3 of a third block is on the output.
    send_block(8'h90, rand_elems());
    repeat (3) @(negedge clk_i);
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    check_eq("arst_valid", 64'(out_valid_o), 64'd0);
    check_eq("arst_last", 64'(out_last_o), 64'd0);
    check_eq("arst_data", out_data_o, 64'd0);
    check_eq("arst_flags", 64'({out_uflow_o, out_oflow_o}), 64'd0);
    check_eq("arst_in_ready", 64'(in_ready_o), 64'd1);
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    check_eq("post_rst_in_ready", 64'(in_ready_o), 64'd1);
    check_eq("post_rst_valid", 64'(out_valid_o), 64'd0);
    @(posedge clk_i); #1;

    // Random blocks under random backpressure.
    rdy_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] s;
      case ($urandom_range(0, 7))
        0: s = 8'hFF;
        1: s = 8'h00;
        2: s = 8'hFE;
        3: s = 8'h01;
        default: s = 8'($urandom);
      endcase
      e = rand_elems();
      for (int k = 0; k < BS; k++) begin
        case ($urandom_range(0, 7))
          0: e[8*k +: 8] = 8'h80;
          1: e[8*k +: 8] = 8'h00;
          2: e[8*k +: 8] = 8'h7F;
          default: ;
        endcase
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_i); #1;
      end
      send_block(s, e);
    end
    wait_idle();
    rdy_rand = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule
